// File: rtl/serial_adder_pkg.sv
// Shared definitions for serial_adder: FSM state type, digit-count helper and
// the configuration check used at elaboration.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned digit);
        return (width >= 2) && (digit != 0) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder; chained DIGIT times inside serial_adder.
module fa_cell (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);

    logic w_p;

    assign w_p = A ^ B;
    assign S   = w_p ^ Ci;
    assign Co  = (A & B) | (Ci & w_p);

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor, DIGIT bits per clock, LSB digit first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output OVF.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             OVF
`endif
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic             r_co;
    logic [CW-1:0]    r_cnt;
    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_dig;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_accept;
    logic             w_last;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    assign w_c[0] = r_carry;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_ripple
        fa_cell u_fa (
            .A  (r_a[gi]),
            .B  (r_b[gi]),
            .Ci (w_c[gi]),
            .S  (w_dig[gi]),
            .Co (w_c[gi+1])
        );
    end

    // New digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG shifts.
    assign w_sum_next = (r_sum >> DIGIT) | (WIDTH'(w_dig) << (WIDTH - DIGIT));
    assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start;
    assign w_last     = (r_cnt == CW'(NDIG - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= SUB ? ~B : B;
            r_carry <= SUB ? 1'b1 : Ci;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> DIGIT;
            r_b     <= r_b >> DIGIT;
            r_sum   <= w_sum_next;
            r_carry <= w_c[DIGIT];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_s   <= w_sum_next;
                r_co  <= w_c[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                r_ovf <= w_c[DIGIT] ^ w_c[DIGIT-1];
`endif
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign S    = r_s;
    assign Co   = r_co;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Randomised and directed bench for serial_adder: an 8-bit/1-digit and a
// 16-bit/4-digit instance, both checked against a plain-arithmetic model.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        st8 = 1'b0, sub8 = 1'b0, ci8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, co8;
    logic [7:0]  s8;

    logic        st16 = 1'b0, sub16 = 1'b0, ci16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, co16;
    logic [15:0] s16;

`ifdef SERIAL_ADDER_OVF_EN
    logic        ovf8, ovf16;
`endif

    int          total = 0;
    int          bad   = 0;
    int          sel   = 0;
    logic [15:0] prev8 = '0, prev16 = '0;

    logic        sel_done, sel_busy, sel_co, sel_ovf;
    logic [15:0] sel_s;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (st8),
        .SUB   (sub8),
        .A     (a8),
        .B     (b8),
        .Ci    (ci8),
        .busy  (busy8),
        .done  (done8),
        .S     (s8),
        .Co    (co8)
`ifdef SERIAL_ADDER_OVF_EN
       ,.OVF   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk   (clk),
        .rst   (rst),
        .start (st16),
        .SUB   (sub16),
        .A     (a16),
        .B     (b16),
        .Ci    (ci16),
        .busy  (busy16),
        .done  (done16),
        .S     (s16),
        .Co    (co16)
`ifdef SERIAL_ADDER_OVF_EN
       ,.OVF   (ovf16)
`endif
    );

    always_comb begin
        sel_done = (sel != 0) ? done16 : done8;
        sel_busy = (sel != 0) ? busy16 : busy8;
        sel_co   = (sel != 0) ? co16   : co8;
        sel_s    = (sel != 0) ? s16    : {8'h00, s8};
        sel_ovf  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        sel_ovf  = (sel != 0) ? ovf16 : ovf8;
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic on the effective operands.
    task automatic model(input int w, input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, output logic [15:0] s, output logic co, output logic ovf);
        logic [16:0] mask, be, tot;
        mask = (17'd1 << w) - 17'd1;
        be   = sub ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        tot  = ({1'b0, a} & mask) + be + (sub ? 17'd1 : {16'd0, ci});
        s    = tot[15:0] & mask[15:0];
        co   = tot[w];
        ovf  = (a[w-1] == be[w-1]) && (s[w-1] != a[w-1]);
    endtask

    task automatic drive(input int which, input logic st, input logic sub,
                         input logic [15:0] a, input logic [15:0] b, input logic ci);
        if (which != 0) begin
            st16 = st; sub16 = sub; a16 = a; b16 = b; ci16 = ci;
        end else begin
            st8 = st; sub8 = sub; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci;
        end
    endtask

    task automatic do_op(input int which, input logic sub, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic poke, input string tag);
        int          w, nd, cyc;
        logic [15:0] es, prev, am, bm;
        logic        eco, eovf;
        w    = (which != 0) ? 16 : 8;
        nd   = (which != 0) ? 4 : 8;
        am   = (which != 0) ? a : {8'h00, a[7:0]};
        bm   = (which != 0) ? b : {8'h00, b[7:0]};
        prev = (which != 0) ? prev16 : prev8;
        sel  = which;
        model(w, sub, am, bm, ci, es, eco, eovf);
        drive(which, 1'b1, sub, am, bm, ci);
        @(posedge clk); #1;
        drive(which, 1'b0, $urandom % 2 == 1, 16'($urandom), 16'($urandom), $urandom % 2 == 1);
        cyc = 1;
        check({tag, "_busy"}, 32'(sel_busy), 32'd1);
        while (!sel_done && cyc < nd + 10) begin
            if (cyc == 2) begin
                check({tag, "_hold"}, 32'(sel_s), 32'(prev));
                if (poke) begin
                    if (which != 0) st16 = 1'b1; else st8 = 1'b1;
                end
            end
            if (cyc == 3) begin
                st16 = 1'b0; st8 = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(nd + 1));
        check({tag, "_S"}, 32'(sel_s), 32'(es));
        check({tag, "_Co"}, 32'(sel_co), 32'(eco));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_OVF"}, 32'(sel_ovf), 32'(eovf));
`endif
        check({tag, "_dbusy"}, 32'(sel_busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_one_done"}, {31'd0, sel_done | sel_busy}, 32'd0);
        if (which != 0) prev16 = es; else prev8 = es;
    endtask

    task automatic reset_mid_run();
        int ndone;
        sel = 0;
        drive(0, 1'b1, 1'b0, 16'h00AB, 16'h0044, 1'b1);
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_run_busy_before", 32'(busy8), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_S", 32'(s8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_Co", 32'(co8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        prev8 = '0; prev16 = '0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
    endtask

    task automatic back_to_back();
        int          cyc;
        logic [7:0]  x, y;
        logic [15:0] e1;
        sel = 0;
        x  = 8'($urandom);
        y  = 8'($urandom);
        e1 = {8'h00, 8'(x + y)};
        drive(0, 1'b1, 1'b0, {8'h00, x}, {8'h00, y}, 1'b0);
        @(posedge clk); #1;
        a8 = 8'h10; b8 = 8'h20;
        cyc = 1;
        while (!done8 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_first_lat", 32'(cyc), 32'd9);
        check("b2b_first_S", 32'(s8), 32'(e1));
        @(posedge clk); #1;
        st8 = 1'b0;
        cyc = 1;
        check("b2b_rebusy", 32'(busy8), 32'd1);
        while (!done8 && cyc < 30) begin
            if (cyc == 4) check("b2b_S_held", 32'(s8), 32'(e1));
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_gap", 32'(cyc), 32'd9);
        check("b2b_second_S", 32'(s8), 32'h30);
        check("b2b_second_Co", 32'(co8), 32'd0);
        @(posedge clk); #1;
        check("b2b_idle", {31'd0, done8 | busy8}, 32'd0);
        prev8 = 16'h0030;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy8", 32'(busy8), 32'd0);
        check("reset_done8", 32'(done8), 32'd0);
        check("reset_S8", 32'(s8), 32'd0);
        check("reset_Co8", 32'(co8), 32'd0);
        check("reset_busy16", 32'(busy16), 32'd0);
        check("reset_S16", 32'(s16), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_OVF8", 32'(ovf8), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(0, 1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, "ff_plus_1");
        do_op(0, 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0, "sub_5_7");
        do_op(0, 1'b0, 16'h007F, 16'h0001, 1'b0, 1'b0, "ovf_7f_1");
        do_op(0, 1'b0, 16'h0080, 16'h0080, 1'b0, 1'b0, "ovf_80_80");
        do_op(1, 1'b0, 16'h1234, 16'h0FCD, 1'b1, 1'b1, "w16_poke");
        do_op(1, 1'b1, 16'h0000, 16'h0001, 1'b0, 1'b0, "w16_sub_borrow");

        reset_mid_run();
        do_op(0, 1'b0, 16'h0033, 16'h0044, 1'b1, 1'b0, "after_rst");
        back_to_back();

        for (int i = 0; i < 20; i++) begin
            do_op(0, $urandom % 2 == 1, 16'($urandom), 16'($urandom), $urandom % 2 == 1,
                  $urandom % 2 == 1, "rnd8");
            do_op(1, $urandom % 2 == 1, 16'($urandom), 16'($urandom), $urandom % 2 == 1,
                  $urandom % 2 == 1, "rnd16");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
